reg_writeback_queue: RTL and testbench
======================================

// Module: reg_writeback_queue
// PURPOSE
//   Write-back stage directly upstream of the 32x32 register file write port.
//   Accepts results from two producers (ALU port A, load port B), buffers them in
//   an in-order queue and drains one entry per cycle onto the register file's
//   WRITE/ADDR_W/DATA_W inputs. A lookup port reports pending writes to the operand-read stage.
// PARAMETERS
//   DEPTH   4   queue entries; power of two, >= 2
//   PTR_W   2   log2(DEPTH); head/tail pointer width
//   Address/data widths come from `REG_ADDR_INDEX_LIMIT / `DATA_INDEX_LIMIT (prj_definition.v).
// PORTS
//   CLK        in   1    clock; all state updates on posedge
//   RST        in   1    synchronous, active-high reset
//   A_VALID    in   1    ALU result valid
//   A_ADDR     in   5    ALU destination register
//   A_DATA     in   32   ALU result
//   A_READY    out  1    port A can be accepted this cycle
//   B_VALID    in   1    load result valid
//   B_ADDR     in   5    load destination register
//   B_DATA     in   32   load result
//   B_READY    out  1    port B can be accepted this cycle
//   RF_STALL   in   1    hold drain (register file busy)
//   RF_WRITE   out  1    write strobe to register file
//   RF_ADDR_W  out  5    register file write address
//   RF_DATA_W  out  32   register file write data
//   LK_ADDR    in   5    register address to check against pending entries
//   LK_HIT     out  1    LK_ADDR matches a valid queued entry
//   LK_DATA    out  32   data of newest matching entry (see CONFIGURATION)
//   COUNT      out  3    current occupancy, 0..DEPTH
// BEHAVIOUR
//   - Reset: head=tail=0, COUNT=0, RF_WRITE=0, RF_ADDR_W=0, RF_DATA_W=0; entries invalidated.
//     RST mid-operation discards all pending entries; nothing is written out that cycle.
//   - Handshake: transfer on VALID&READY at posedge. READY is derived from registered COUNT
//     only (a same-cycle drain does not free space): free=DEPTH-COUNT.
//     free>=2: A_READY=B_READY=1; free==1: A_READY=1, B_READY=~A_VALID; free==0: both 0.
//   - Order: if both accepted in one cycle, A is enqueued ahead of B.
//   - Address 0: accepted (handshake completes) but not enqueued; COUNT unchanged.
//   - Drain FSM: IDLE (COUNT==0) / DRAIN (COUNT>0). In DRAIN with RF_STALL=0, head entry is
//     presented registered: RF_WRITE=1, RF_ADDR_W/RF_DATA_W = head, head advances, COUNT-1.
//     RF_STALL=1 or IDLE: RF_WRITE=0, address/data hold last values.
//   - Latency: entry accepted at edge N into empty queue appears on RF_* after edge N+1.
//   - Simultaneous enqueue(s) and drain: COUNT += accepted - drained; pointers wrap mod DEPTH.
//   - Lookup is combinational over valid entries; entry being driven on RF_* this cycle
//     is no longer counted as pending. LK_ADDR==0 => LK_HIT=0.
// CONFIGURATION
//   WBQ_BYPASS_EN defined: LK_HIT=1 on match, LK_DATA=data of youngest matching entry
//     (consumer forwards it instead of register file value).
//   Not defined: LK_HIT=1 on match acts as hazard flag (consumer stalls); LK_DATA=0 always.
// STRUCTURE
//   Shared constants: widths from prj_definition.v; add `WBQ_DEPTH and drain-state
//   encodings (`WBQ_IDLE, `WBQ_DRAIN) there.
//   One sub-module: reg_wbq_entry_store (DEPTH x {valid,addr,data} array, write by tail,
//   read by head, parallel address-match outputs). Arbiter, pointers and FSM in top.
// TESTING
//   1. RST=1 two cycles -> COUNT=0, RF_WRITE=0, A_READY=B_READY=1, LK_HIT=0.
//   2. A: addr 5 data 0x55 only -> one cycle later RF_WRITE=1, RF_ADDR_W=5, RF_DATA_W=0x55; then COUNT=0.
//   3. A(3,0x30)+B(3,0x31) same cycle -> RF writes 0x30 then 0x31 to r3; mid-way LK_ADDR=3
//      gives LK_HIT=1, LK_DATA=0x31 with WBQ_BYPASS_EN, LK_DATA=0 without.
//   4. RF_STALL=1, fill 4 entries -> COUNT=4, A_READY=B_READY=0; release stall -> 4 writes
//      in order on consecutive cycles, pointers wrap, COUNT returns to 0.
//   5. COUNT=3, A and B both valid -> only A accepted, B_READY=0; B accepted next cycle.
//   6. A(addr 0, 0xFF) -> A_READY=1, COUNT stays 0, no RF_WRITE; RST with 2 pending -> no writes.

Source files
------------

// File: rtl/reg_writeback_queue_pkg.sv
// Shared widths, queue sizing and drain-FSM encodings for the register write-back queue.
package reg_writeback_queue_pkg;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;
  localparam int WBQ_DEPTH = 4;
  localparam int WBQ_PTR_W = 2;

  localparam logic [0:0] WBQ_IDLE  = 1'b0;
  localparam logic [0:0] WBQ_DRAIN = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/reg_writeback_queue_if.sv
// Bundle of producer, register-file, lookup and status signals around the write-back queue.
interface reg_writeback_queue_if
  import reg_writeback_queue_pkg::*;
#(
  parameter int PTR_W = WBQ_PTR_W
) ();
  // X_VALID/X_READY: a result transfers at the rising edge where both are high;
  // READY never depends on the same-cycle drain, only on registered occupancy.
  logic              A_VALID;
  logic [ADDR_W-1:0] A_ADDR;
  logic [DATA_W-1:0] A_DATA;
  logic              A_READY;
  logic              B_VALID;
  logic [ADDR_W-1:0] B_ADDR;
  logic [DATA_W-1:0] B_DATA;
  logic              B_READY;
  logic              RF_STALL;
  logic              RF_WRITE;
  logic [ADDR_W-1:0] RF_ADDR_W;
  logic [DATA_W-1:0] RF_DATA_W;
  logic [ADDR_W-1:0] LK_ADDR;
  logic              LK_HIT;
  logic [DATA_W-1:0] LK_DATA;
  logic [PTR_W:0]    COUNT;
  logic [0:0]        DBG_STATE;

  modport slave (
    input  A_VALID, A_ADDR, A_DATA, B_VALID, B_ADDR, B_DATA, RF_STALL, LK_ADDR,
    output A_READY, B_READY, RF_WRITE, RF_ADDR_W, RF_DATA_W, LK_HIT, LK_DATA, COUNT, DBG_STATE
  );

  modport master (
    output A_VALID, A_ADDR, A_DATA, B_VALID, B_ADDR, B_DATA, RF_STALL, LK_ADDR,
    input  A_READY, B_READY, RF_WRITE, RF_ADDR_W, RF_DATA_W, LK_HIT, LK_DATA, COUNT, DBG_STATE
  );
endinterface

// File: rtl/reg_wbq_entry_store.sv
// DEPTH-entry {valid,addr,data} store: two writes at tail, read/clear at head, parallel lookup.
// WBQ_BYPASS_EN: when defined, lk_data carries the youngest matching entry's data.
module reg_wbq_entry_store
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH,
  parameter int PTR_W = WBQ_PTR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr0_en,
  input  logic [PTR_W-1:0]  wr0_idx,
  input  wb_entry_t         wr0_entry,
  input  logic              wr1_en,
  input  logic [PTR_W-1:0]  wr1_idx,
  input  wb_entry_t         wr1_entry,
  input  logic              clr_en,
  input  logic [PTR_W-1:0]  rd_idx,
  output wb_entry_t         rd_entry,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic [DEPTH-1:0]  lk_match,
  output logic [DATA_W-1:0] lk_data
);
  logic [DEPTH-1:0]      valid_q, valid_d;
  wb_entry_t [DEPTH-1:0] entry_q, entry_d;

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (clr_en) valid_d[rd_idx] = 1'b0;
    if (wr0_en) begin
      valid_d[wr0_idx] = 1'b1;
      entry_d[wr0_idx] = wr0_entry;
    end
    if (wr1_en) begin
      valid_d[wr1_idx] = 1'b1;
      entry_d[wr1_idx] = wr1_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign rd_entry = entry_q[rd_idx];

  always_comb begin
    lk_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lk_match[i] = valid_q[i] && (entry_q[i].addr == lk_addr);
    end
  end

  // Walk oldest to youngest from the head so the last match found is the newest.
  always_comb begin
    lk_data = '0;
`ifdef WBQ_BYPASS_EN
    for (int k = 0; k < DEPTH; k++) begin
      if (lk_match[rd_idx + PTR_W'(k)]) lk_data = entry_q[rd_idx + PTR_W'(k)].data;
    end
`endif
  end
endmodule

// File: rtl/reg_writeback_queue.sv
// In-order write-back queue feeding the register file write port from an ALU and a load port.
// WBQ_BYPASS_EN (in the entry store) selects forwarding lookup data versus a pure hazard flag.
module reg_writeback_queue
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH,
  parameter int PTR_W = WBQ_PTR_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  reg_writeback_queue_if.slave  wb
);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_C   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] TWO_C   = (PTR_W+1)'(2);

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]    count_q, count_d, free;
  logic [0:0]        state_q, state_d;
  logic              rf_write_q, rf_write_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;
  logic              a_ready, b_ready, enq_a, enq_b, drain;
  logic [1:0]        n_enq;
  wb_entry_t         a_entry, b_entry, head_entry;
  logic [DEPTH-1:0]  lk_match;
  logic [DATA_W-1:0] lk_data;

  // Register 0 is hardwired; such results complete the handshake but are dropped.
  always_comb begin
    free    = DEPTH_C - count_q;
    a_ready = (free != '0);
    b_ready = (free >= TWO_C) || ((free == ONE_C) && !wb.A_VALID);
    enq_a   = wb.A_VALID && a_ready && (wb.A_ADDR != '0);
    enq_b   = wb.B_VALID && b_ready && (wb.B_ADDR != '0);
    n_enq   = {1'b0, enq_a} + {1'b0, enq_b};
    drain   = (state_q == WBQ_DRAIN) && !wb.RF_STALL;
    a_entry.addr = wb.A_ADDR;
    a_entry.data = wb.A_DATA;
    b_entry.addr = wb.B_ADDR;
    b_entry.data = wb.B_DATA;
  end

  reg_wbq_entry_store #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_store (
    .clk       (CLK),
    .rst       (RST),
    .wr0_en    (enq_a),
    .wr0_idx   (tail_q),
    .wr0_entry (a_entry),
    .wr1_en    (enq_b),
    .wr1_idx   (tail_q + PTR_W'(enq_a)),
    .wr1_entry (b_entry),
    .clr_en    (drain),
    .rd_idx    (head_q),
    .rd_entry  (head_entry),
    .lk_addr   (wb.LK_ADDR),
    .lk_match  (lk_match),
    .lk_data   (lk_data)
  );

  always_comb begin
    head_d     = head_q + PTR_W'(drain);
    tail_d     = tail_q + PTR_W'(n_enq);
    count_d    = count_q + (PTR_W+1)'(n_enq) - (PTR_W+1)'(drain);
    state_d    = (count_d != '0) ? WBQ_DRAIN : WBQ_IDLE;
    rf_write_d = drain;
    rf_addr_d  = rf_addr_q;
    rf_data_d  = rf_data_q;
    if (drain) begin
      rf_addr_d = head_entry.addr;
      rf_data_d = head_entry.data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      state_q    <= WBQ_IDLE;
      rf_write_q <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      state_q    <= state_d;
      rf_write_q <= rf_write_d;
      rf_addr_q  <= rf_addr_d;
      rf_data_q  <= rf_data_d;
    end
  end

  assign wb.A_READY   = a_ready;
  assign wb.B_READY   = b_ready;
  assign wb.RF_WRITE  = rf_write_q;
  assign wb.RF_ADDR_W = rf_addr_q;
  assign wb.RF_DATA_W = rf_data_q;
  assign wb.LK_HIT    = (|lk_match) && (wb.LK_ADDR != '0);
  assign wb.LK_DATA   = lk_data;
  assign wb.COUNT     = count_q;
  assign wb.DBG_STATE = state_q;
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Randomized plus directed bench for reg_writeback_queue against a queue-based reference model.
module tb_reg_writeback_queue;
  import reg_writeback_queue_pkg::*;

  localparam int DEPTH = WBQ_DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_writeback_queue_if wb ();

  reg_writeback_queue dut (
    .CLK (clk),
    .RST (rst),
    .wb  (wb)
  );

  // Pending writes in program order, each {addr, data}.
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic                     exp_wr;
  logic [ADDR_W-1:0]        exp_addr;
  logic [DATA_W-1:0]        exp_data;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_idle();
    wb.A_VALID = 1'b0; wb.A_ADDR = '0; wb.A_DATA = '0;
    wb.B_VALID = 1'b0; wb.B_ADDR = '0; wb.B_DATA = '0;
    wb.RF_STALL = 1'b0; wb.LK_ADDR = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_wr = 1'b0; exp_addr = '0; exp_data = '0;
    check_eq("rst_rf_write", 32'(wb.RF_WRITE), 32'(exp_wr));
    check_eq("rst_rf_addr", 32'(wb.RF_ADDR_W), 32'(exp_addr));
    check_eq("rst_rf_data", wb.RF_DATA_W, exp_data);
    check_eq("rst_count", 32'(wb.COUNT), 0);
  endtask

  // One clock cycle: drive, check combinational outputs mid-cycle, advance model, check RF.
  task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                      input logic stall, input logic [4:0] lk);
    int occ;
    logic ea, eb, ehit;
    logic [31:0] edata;
    logic [ADDR_W+DATA_W-1:0] e;
    wb.A_VALID = av; wb.A_ADDR = aa; wb.A_DATA = ad;
    wb.B_VALID = bv; wb.B_ADDR = ba; wb.B_DATA = bd;
    wb.RF_STALL = stall; wb.LK_ADDR = lk;
    @(negedge clk);
    occ = exp_q.size();
    ea = (occ < DEPTH);
    eb = ((DEPTH - occ) >= 2) || (((DEPTH - occ) == 1) && !av);
    check_eq("a_ready", 32'(wb.A_READY), 32'(ea));
    check_eq("b_ready", 32'(wb.B_READY), 32'(eb));
    ehit = 1'b0;
    edata = '0;
    if (lk != 0) begin
      foreach (exp_q[i]) begin
        if (exp_q[i][ADDR_W+DATA_W-1:DATA_W] == lk) begin
          ehit = 1'b1;
          edata = exp_q[i][DATA_W-1:0];
        end
      end
    end
`ifndef WBQ_BYPASS_EN
    edata = '0;
`endif
    check_eq("lk_hit", 32'(wb.LK_HIT), 32'(ehit));
    check_eq("lk_data", wb.LK_DATA, edata);
    check_eq("count", 32'(wb.COUNT), 32'(occ));
    check_eq("state", 32'(wb.DBG_STATE), 32'(occ > 0));
    if (occ > 0 && !stall) begin
      e = exp_q.pop_front();
      exp_wr = 1'b1;
      exp_addr = e[ADDR_W+DATA_W-1:DATA_W];
      exp_data = e[DATA_W-1:0];
    end else begin
      exp_wr = 1'b0;
    end
    if (av && ea && aa != 0) exp_q.push_back({aa, ad});
    if (bv && eb && ba != 0) exp_q.push_back({ba, bd});
    @(posedge clk);
    #1;
    check_eq("rf_write", 32'(wb.RF_WRITE), 32'(exp_wr));
    check_eq("rf_addr", 32'(wb.RF_ADDR_W), 32'(exp_addr));
    check_eq("rf_data", wb.RF_DATA_W, exp_data);
  endtask

  task automatic idle_step(input logic stall, input logic [4:0] lk);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, stall, lk);
  endtask

  initial begin
    drive_idle();
    do_reset();

    // Reset state and single ALU write with one-cycle drain latency.
    idle_step(1'b0, 5'd0);
    step(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'h0, 1'b0, 5'd5);
    idle_step(1'b0, 5'd5);
    check_eq("t2_addr", 32'(wb.RF_ADDR_W), 32'd5);
    check_eq("t2_data", wb.RF_DATA_W, 32'h55);
    idle_step(1'b0, 5'd0);
    check_eq("t2_count", 32'(wb.COUNT), 0);

    // Same-cycle A then B to the same register; lookup must see the younger one.
    step(1'b1, 5'd3, 32'h30, 1'b1, 5'd3, 32'h31, 1'b0, 5'd3);
    idle_step(1'b0, 5'd3);
    check_eq("t3_first", wb.RF_DATA_W, 32'h30);
    idle_step(1'b0, 5'd3);
    check_eq("t3_second", wb.RF_DATA_W, 32'h31);
    idle_step(1'b0, 5'd3);

    // Fill under stall, refuse while full, then drain four in order with wrap.
    for (int i = 0; i < 2; i++)
      step(1'b1, 5'(10 + 2*i), 32'hA0 + i, 1'b1, 5'(11 + 2*i), 32'hB0 + i, 1'b1, 5'd12);
    step(1'b1, 5'd20, 32'hDEAD, 1'b1, 5'd21, 32'hBEEF, 1'b1, 5'd11);
    check_eq("t4_full", 32'(wb.COUNT), 32'(DEPTH));
    for (int i = 0; i < 5; i++) idle_step(1'b0, 5'd13);

    // Three entries queued: only A fits, B follows once a drain frees a slot.
    for (int i = 0; i < 3; i++) step(1'b1, 5'(1 + i), 32'h100 + i, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
    step(1'b1, 5'd7, 32'h700, 1'b1, 5'd8, 32'h800, 1'b0, 5'd2);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h800, 1'b0, 5'd8);
    for (int i = 0; i < 5; i++) idle_step(1'b0, 5'd8);

    // Address 0 is accepted but never written; reset drops pending entries.
    step(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    idle_step(1'b0, 5'd0);
    step(1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66, 1'b1, 5'd0);
    do_reset();
    idle_step(1'b0, 5'd4);
    idle_step(1'b0, 5'd6);

    // Random traffic with occasional mid-stream reset.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      step(1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 6; i++) idle_step(1'b0, 5'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
